iir_static_notch: RTL and testbench
===================================

Name: iir_static_notch

Overview:
- Fixed-coefficient second-order IIR (biquad) notch filter for the audio equalizer path.
- Takes 24-bit signed PCM samples at 40 kHz and produces a 29-bit signed filtered sample per input sample.
- Runs entirely on the 240 kHz system clock. The 40 kHz sample-rate square wave is a data input used only as a sample strobe.
- Arithmetic is a serial multiply-accumulate: six system clocks per sample.

Parameters:
- DW, 24, input sample width (signed).
- OW, 29, output sample width (signed).
- CW, 13, coefficient width (signed, Q12 scaling).
- SH, 12, coefficient fractional bits (right shift after accumulate).
- B0, 4096, feed-forward coefficient x[n].
- B1, -5793, feed-forward coefficient x[n-1].
- B2, 4096, feed-forward coefficient x[n-2].
- A1, -5213, feedback coefficient y[n-1] (subtracted).
- A2, 3318, feedback coefficient y[n-2] (subtracted).

Ports:
- clk_240k  in  1  system clock, 240 kHz; the only clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- clk_40k  in  1  40 kHz sample-rate signal; sampled as data, never used as a clock.
- Din  in  24  signed input sample; held stable for the whole clk_40k period.
- Dout  out  29  signed filtered output, registered.

Behaviour:
- Interface: one clock (clk_240k); reset is synchronous and active-high (rst).
- Reset:
  - Dout, the x[n-1], x[n-2], y[n-1], y[n-2] history registers, the accumulator, the state and the synchronizer flops all clear to 0.
  - Reset asserted mid-computation aborts the computation and discards the partial accumulator.
- Strobe generation:
  - clk_40k passes through a 2-flop synchronizer, then a rising-edge detect.
  - This produces a 1-cycle strobe `stb` once per 6 clocks.
- State machine: IDLE -> LOAD -> MAC (5 cycles) -> IDLE.
- IDLE: wait for `stb`.
- LOAD (the cycle `stb` is high):
  - Capture Din into x0.
  - Clear the accumulator.
  - Set the MAC index to 0.
- MAC, index 0..4; one product added per cycle, in this order:
  - B0*x0, B1*x1, B2*x2, -A1*y1, -A2*y2.
- Completion (same clock as the final MAC step): y = acc >>> SH, arithmetic shift, floor rounding. Then:
  - Dout <= y.
  - x2 <= x1, x1 <= x0.
  - y2 <= y1, y1 <= y (the saturated value).
  - Return to IDLE.
- Latency: Dout updates on the 6th rising edge after the edge that registered `stb`. It holds until the next sample's completion.
- Widths:
  - Products are sign-extended.
  - The accumulator is 44 bits signed; it never wraps for any legal input.
- Saturation: y is saturated to the 29-bit signed range [-2^28, 2^28-1] before it goes to Dout and y1.
- Overrun: a `stb` arriving while not in IDLE is ignored and that sample is dropped. This cannot happen with the nominal 6:1 clock ratio.
- Transfer function: H(z) = (1 - 1.41421 z^-1 + z^-2)/(1 - 1.27279 z^-1 + 0.81 z^-2).
  - Notch at fs/8 = 5 kHz.
  - Pole radius 0.9.
  - DC gain 2399/2201 ≈ 1.0900.

Test Plan:
- Reset: hold rst high for 10 clocks with toggling clk_40k and Din=123456 -> Dout=0 throughout. History is zero, so the first post-reset impulse matches the impulse test exactly.
- Impulse: Din=4096 for one sample, then 0 -> Dout sequence 4096, -580, 39, …, each appearing 6 clocks after its sample strobe. Bench checks the first 3 values exactly and the decaying oscillation after that.
- DC step: Din=100000 held for 200 samples -> Dout settles to 108996 ±2 and stays constant.
- Notch: Din = 1,000,000·sin(2πn/8) (5 kHz) for 400 samples -> after 100 samples, |Dout| < 10,000.
- Passband: Din = 1,000,000·sin(2πn·0.5/40) (500 Hz) -> settled peak |Dout| within 5% of the analytic |H| times the input amplitude.
- Full scale and mid-run reset:
  - Din = -8388608 held -> Dout settles near -9143000 with no wrap or sign flip.
  - Then assert rst mid-MAC -> Dout=0 on the next clock, and filtering restarts cleanly from zero state.

Source files
------------

// File: rtl/iir_static_notch.sv
// iir_static_notch: fixed-coefficient biquad notch (5 kHz at fs = 40 kHz).
// One serial multiply-accumulate per system clock, six clocks per sample:
// a load cycle on the sample strobe, then five MAC cycles. The last MAC cycle
// also shifts, saturates, updates the output and rotates the history.
module iir_static_notch #(
  parameter int DW = 24,     // input sample width
  parameter int OW = 29,     // output sample width
  parameter int CW = 13,     // nominal Q12 coefficient width
  parameter int SH = 12,     // coefficient fractional bits
  parameter int B0 = 4096,
  parameter int B1 = -5793,
  parameter int B2 = 4096,
  parameter int A1 = -5213,
  parameter int A2 = 3318
) (
  input  logic                 clk_240k,
  input  logic                 rst,
  input  logic                 clk_40k,
  input  logic signed [DW-1:0] Din,
  output logic signed [OW-1:0] Dout
);

  // |B1| and |A1| exceed 1.0 in Q12, so the coefficient path carries one
  // integer bit beyond CW.
  localparam int KW = CW + 1;
  localparam int PW = KW + OW;   // product width
  localparam int AW = 44;        // accumulator width, no wrap for legal input

  localparam logic signed [AW-1:0] YMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {S_IDLE, S_MAC} state_t;

  state_t                r_state;
  logic [2:0]            r_idx;
  logic                  r_sync1, r_sync2, r_sync3;
  logic signed [DW-1:0]  r_x0, r_x1, r_x2;
  logic signed [OW-1:0]  r_y1, r_y2;
  logic signed [AW-1:0]  r_acc;
  logic signed [OW-1:0]  r_dout;

  logic                  w_stb;
  logic signed [KW-1:0]  w_coef;
  logic signed [OW-1:0]  w_opnd;
  logic signed [PW-1:0]  w_prod;
  logic signed [AW-1:0]  w_acc_nxt;
  logic signed [AW-1:0]  w_shift;
  logic signed [OW-1:0]  w_ysat;

  // Two-flop synchronizer on the sample-rate signal plus a delayed copy for edge detect
  always_ff @(posedge clk_240k) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= clk_40k;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_stb = r_sync2 & ~r_sync3;

  // Coefficient/operand select for the current MAC step; feedback terms enter negated
  always_comb begin
    w_coef = '0;
    w_opnd = '0;
    case (r_idx)
      3'd0: begin w_coef = KW'(B0);  w_opnd = {{(OW-DW){r_x0[DW-1]}}, r_x0}; end
      3'd1: begin w_coef = KW'(B1);  w_opnd = {{(OW-DW){r_x1[DW-1]}}, r_x1}; end
      3'd2: begin w_coef = KW'(B2);  w_opnd = {{(OW-DW){r_x2[DW-1]}}, r_x2}; end
      3'd3: begin w_coef = KW'(-A1); w_opnd = r_y1; end
      3'd4: begin w_coef = KW'(-A2); w_opnd = r_y2; end
      default: begin w_coef = '0; w_opnd = '0; end
    endcase
  end

  assign w_prod    = w_coef * w_opnd;
  assign w_acc_nxt = r_acc + {{(AW-PW){w_prod[PW-1]}}, w_prod};
  assign w_shift   = w_acc_nxt >>> SH;   // arithmetic shift: floor rounding

  // Clamp the scaled result to the signed output range
  always_comb begin
    w_ysat = w_shift[OW-1:0];
    if (w_shift > YMAX)      w_ysat = YMAX[OW-1:0];
    else if (w_shift < YMIN) w_ysat = YMIN[OW-1:0];
  end

  // Sequencer and datapath: load on strobe, five MAC steps, commit on the last
  always_ff @(posedge clk_240k) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_y1    <= '0;
      r_y2    <= '0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // the strobe cycle itself is the load step
          if (w_stb) begin
            r_x0    <= Din;
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          // strobes arriving here are dropped on purpose (overrun)
          r_acc <= w_acc_nxt;
          if (r_idx == 3'd4) begin
            r_dout  <= w_ysat;
            r_x2    <= r_x1;
            r_x1    <= r_x0;
            r_y2    <= r_y1;
            r_y1    <= w_ysat;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Dout = r_dout;

endmodule

// File: tb/tb_iir_static_notch.sv
// Bench for iir_static_notch: difference-equation reference model with a
// latency queue, per-cycle output compare, and literal/analytic checks.
`timescale 1ns/1ps
module tb_iir_static_notch;

  localparam int     CB0 = 4096, CB1 = -5793, CB2 = 4096, CA1 = -5213, CA2 = 3318;
  localparam longint YMAX = 268435455;
  localparam longint YMIN = -268435456;
  localparam real    PI   = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               c40 = 1'b0;
  logic signed [23:0] din = '0;
  logic signed [28:0] dout;

  iir_static_notch dut (
    .clk_240k (clk),
    .rst      (rst),
    .clk_40k  (c40),
    .Din      (din),
    .Dout     (dout)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic rst_q = 1'b1;

  typedef struct { int cyc; int val; } ev_t;
  ev_t    exp_q[$];
  int     exp_dout = 0;
  int     dut_h[$];
  int     mod_h[$];
  longint mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected in [%0d,%0d]", nm, act, lo, hi);
    end
  endtask

  always @(posedge clk) rst_q <= rst;

  // Per-cycle compare against the model's expected output
  always @(negedge clk) begin
    bit upd;
    upd = 1'b0;
    if (rst_q) begin
      exp_q.delete();
      exp_dout = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_dout = exp_q[0].val;
        void'(exp_q.pop_front());
        upd = 1'b1;
      end
    end
    chk("dout_track", longint'(dout), longint'(exp_dout));
    if (upd) begin
      dut_h.push_back(int'(dout));
      mod_h.push_back(exp_dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  // Difference equation with floor scaling and saturation; output due 8 edges
  // after the clk_40k rise (2 sync + edge detect, load, 5 MAC steps)
  task automatic model_push(input int x);
    longint acc, y;
    acc = CB0 * longint'(x) + CB1 * mx1 + CB2 * mx2 - CA1 * my1 - CA2 * my2;
    y = acc >>> 12;
    if (y > YMAX) y = YMAX;
    else if (y < YMIN) y = YMIN;
    mx2 = mx1; mx1 = longint'(x);
    my2 = my1; my1 = y;
    exp_q.push_back('{cyc + 8, int'(y)});
  endtask

  // One 6-clock sample period: clk_40k high 3 clocks, low 3 clocks
  task automatic sample(input int x);
    tick();
    c40 = 1'b1;
    din = 24'(x);
    model_push(x);
    tick(); tick();
    tick();
    c40 = 1'b0;
    tick(); tick();
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic clear_hist();
    dut_h.delete();
    mod_h.delete();
  endtask

  function automatic int rnd24();
    logic signed [23:0] r;
    r = 24'($urandom);
    if ($urandom_range(0, 1) == 0) r = r >>> 12;
    return int'(r);
  endfunction

  function automatic longint iabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic impulse_check(input string tag);
    longint mx;
    clear_hist();
    sample(4096);
    repeat (39) sample(0);
    drain();
    chk({tag, "_count"}, dut_h.size(), 40);
    if (dut_h.size() >= 40) begin
      chk({tag, "_mod0"}, mod_h[0], 4096);
      chk({tag, "_mod1"}, mod_h[1], -580);
      chk({tag, "_mod2"}, mod_h[2], 39);
      chk({tag, "_dut0"}, dut_h[0], 4096);
      chk({tag, "_dut1"}, dut_h[1], -580);
      chk({tag, "_dut2"}, dut_h[2], 39);
      mx = 0;
      for (int i = 25; i < 40; i++) if (iabs(dut_h[i]) > mx) mx = iabs(dut_h[i]);
      chk_rng({tag, "_decay"}, mx, 0, 579);
    end
  endtask

  initial begin
    longint mx;
    real    nr, ni, dr, di, hmag, w;
    int     x;

    // reset held with a toggling sample clock and nonzero input
    rst = 1'b1;
    din = 24'sd123456;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i % 3 == 2) c40 = ~c40;
    end
    chk("reset_dout", longint'(dout), 0);
    c40 = 1'b0;
    rst = 1'b0;
    model_clear();
    repeat (4) tick();
    chk("post_reset_idle", longint'(dout), 0);

    impulse_check("imp");

    // random samples, including near full-scale values
    clear_hist();
    for (int i = 0; i < 150; i++) sample(rnd24());
    drain();
    chk("rand_count", dut_h.size(), 150);

    // DC step
    clear_hist();
    repeat (200) sample(100000);
    drain();
    chk("dc_count", dut_h.size(), 200);
    if (dut_h.size() >= 200) begin
      chk_rng("dc_settle", dut_h[199], 108994, 108998);
      chk("dc_steady", dut_h[199], dut_h[180]);
    end

    // notch frequency fs/8
    clear_hist();
    for (int n = 0; n < 400; n++) begin
      x = $rtoi(1.0e6 * $sin(2.0 * PI * n / 8.0));
      sample(x);
    end
    drain();
    chk("notch_count", dut_h.size(), 400);
    if (dut_h.size() >= 400) begin
      mx = 0;
      for (int i = 100; i < 400; i++) if (iabs(dut_h[i]) > mx) mx = iabs(dut_h[i]);
      chk_rng("notch_atten", mx, 0, 9999);
    end

    // passband 500 Hz against analytic magnitude
    clear_hist();
    for (int n = 0; n < 300; n++) begin
      x = $rtoi(1.0e6 * $sin(2.0 * PI * n * 0.5 / 40.0));
      sample(x);
    end
    drain();
    w    = PI / 40.0;
    nr   = 1.0 + (-5793.0 / 4096.0) * $cos(w) + $cos(2.0 * w);
    ni   = -((-5793.0 / 4096.0) * $sin(w) + $sin(2.0 * w));
    dr   = 1.0 + (-5213.0 / 4096.0) * $cos(w) + (3318.0 / 4096.0) * $cos(2.0 * w);
    di   = -((-5213.0 / 4096.0) * $sin(w) + (3318.0 / 4096.0) * $sin(2.0 * w));
    hmag = $sqrt(nr * nr + ni * ni) / $sqrt(dr * dr + di * di);
    chk("pass_count", dut_h.size(), 300);
    if (dut_h.size() >= 300) begin
      mx = 0;
      for (int i = 200; i < 300; i++) if (iabs(dut_h[i]) > mx) mx = iabs(dut_h[i]);
      chk_rng("pass_peak", mx, $rtoi(0.95 * 1.0e6 * hmag), $rtoi(1.05 * 1.0e6 * hmag));
    end

    // negative full scale held
    clear_hist();
    repeat (100) sample(-8388608);
    drain();
    chk("fs_count", dut_h.size(), 100);
    if (dut_h.size() >= 100) chk_rng("fs_settle", dut_h[99], -9144000, -9142000);

    // reset in the middle of a computation
    sample(-8388608);
    rst = 1'b1;
    model_clear();
    tick();
    chk("midrst_dout", longint'(dout), 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("midrst_idle", longint'(dout), 0);

    impulse_check("imp2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
